// File: rtl/proj_pkg.sv
// rtl/proj_pkg.sv - FM scheduler sizing constants and geometry helpers
package proj_pkg;

  localparam int unsigned FM_BUFFER_COUNT              = 2;
  localparam int unsigned FM_RAMS_COUNT                = 2;
  localparam int unsigned FM_ENTRIES_COUNT             = 4;
  localparam int unsigned FM_OFFSET_COUNT              = 2;
  localparam int unsigned FM_EXTENDER_BYTES_READ_COUNT = 4;

  function automatic int unsigned fm_depth(input int unsigned rams,
                                           input int unsigned entries,
                                           input int unsigned offset);
    return rams * entries * offset;
  endfunction

  function automatic int unsigned fm_aw(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // A single buffer still needs a one-bit index port.
  function automatic int unsigned fm_bw(input int unsigned count);
    return (count < 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/proj_fm_ring_ptr.sv
// rtl/proj_fm_ring_ptr.sv - modulo-COUNT index counter advancing on a strobe
module proj_fm_ring_ptr #(
  parameter int unsigned COUNT = 2,
  parameter int unsigned W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  output logic [W-1:0] idx
);

  localparam logic [W-1:0] LAST = W'(COUNT - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (adv) begin
      idx <= (idx == LAST) ? '0 : idx + W'(1);
    end
  end

endmodule

// File: rtl/proj_fm_sched.sv
// rtl/proj_fm_sched.sv - ping-pong buffer scheduler between genome writer and extender reader
module proj_fm_sched
  import proj_pkg::*;
#(
  parameter int unsigned BUFFER_COUNT         = proj_pkg::FM_BUFFER_COUNT,
  parameter int unsigned RAMS                 = proj_pkg::FM_RAMS_COUNT,
  parameter int unsigned ENTRIES              = proj_pkg::FM_ENTRIES_COUNT,
  parameter int unsigned OFFSET               = proj_pkg::FM_OFFSET_COUNT,
  parameter int unsigned READ_ADDRESSES_COUNT = proj_pkg::FM_EXTENDER_BYTES_READ_COUNT,
  localparam int unsigned DEPTH = fm_depth(RAMS, ENTRIES, OFFSET),
  localparam int unsigned AW    = fm_aw(DEPTH),
  localparam int unsigned BW    = fm_bw(BUFFER_COUNT),
  localparam int unsigned CW    = $clog2(BUFFER_COUNT + 1)
) (
  input  logic          in_clk,
  input  logic          in_rst,
  input  logic          in_wr_valid,
  output logic          out_wr_ready,
  output logic          out_wr_en,
  output logic [BW-1:0] out_wr_buf,
  output logic [AW-1:0] out_wr_addr,
  input  logic          in_rd_req,
  input  logic [AW-1:0] in_rd_addr,
  input  logic          in_rd_done,
  output logic          out_rd_en,
  output logic [BW-1:0] out_rd_buf,
  output logic [AW-1:0] out_rd_addr,
  output logic          out_rd_valid,
  output logic          out_rd_err,
  output logic          out_rd_avail,
  output logic [CW-1:0] out_full_count
);

  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
  // Highest window start that keeps the whole window inside one buffer.
  localparam logic [AW-1:0] RD_LIMIT  = AW'(DEPTH - READ_ADDRESSES_COUNT);

  logic [AW-1:0] wr_addr;
  logic [CW-1:0] full_count;
  logic [BW-1:0] wr_buf;
  logic [BW-1:0] rd_buf;
  logic          wr_accept;
  logic          wr_last;
  logic          rd_release;
  logic          rd_ok;
  logic          rd_bad;
  logic          rd_valid_q;
  logic          rd_err_q;

  assign out_wr_ready = full_count < CW'(BUFFER_COUNT);
  assign wr_accept    = in_wr_valid && out_wr_ready;
  assign wr_last      = wr_accept && (wr_addr == ADDR_LAST);
  assign out_rd_avail = full_count != '0;
  assign rd_release   = in_rd_done && out_rd_avail;
  assign rd_ok        = in_rd_req && out_rd_avail && (in_rd_addr <= RD_LIMIT);
  assign rd_bad       = in_rd_req && out_rd_avail && (in_rd_addr > RD_LIMIT);

  assign out_wr_en      = wr_accept;
  assign out_wr_buf     = wr_buf;
  assign out_wr_addr    = wr_addr;
  assign out_rd_en      = rd_ok;
  assign out_rd_buf     = rd_buf;
  assign out_rd_addr    = in_rd_addr;
  assign out_rd_valid   = rd_valid_q;
  assign out_rd_err     = rd_err_q;
  assign out_full_count = full_count;

  proj_fm_ring_ptr #(.COUNT(BUFFER_COUNT), .W(BW)) u_wr_ptr (
    .clk (in_clk),
    .rst (in_rst),
    .adv (wr_last),
    .idx (wr_buf)
  );

  proj_fm_ring_ptr #(.COUNT(BUFFER_COUNT), .W(BW)) u_rd_ptr (
    .clk (in_clk),
    .rst (in_rst),
    .adv (rd_release),
    .idx (rd_buf)
  );

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      wr_addr <= '0;
    end else if (wr_accept) begin
      wr_addr <= wr_last ? '0 : wr_addr + AW'(1);
    end
  end

  // Completion is gated by wr_ready and release by rd_avail, so no over/underflow.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      full_count <= '0;
    end else begin
      case ({wr_last, rd_release})
        2'b10:   full_count <= full_count + CW'(1);
        2'b01:   full_count <= full_count - CW'(1);
        default: full_count <= full_count;
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_ok;
      rd_err_q   <= rd_bad;
    end
  end

endmodule

// File: doc/proj_fm_sched.md
PROJ_FM_SCHED -- requirements
Module: proj_fm_sched

Interface
REQ-001 SHALL have parameters (name, default, meaning): BUFFER_COUNT, proj_pkg::FM_BUFFER_COUNT, ping-pong buffer count; RAMS, proj_pkg::FM_RAMS_COUNT, RAMs per buffer; ENTRIES, proj_pkg::FM_ENTRIES_COUNT, entries per RAM; OFFSET, proj_pkg::FM_OFFSET_COUNT, bytes per entry; READ_ADDRESSES_COUNT, proj_pkg::FM_EXTENDER_BYTES_READ_COUNT, bytes per read window.
REQ-002 SHALL derive DEPTH = RAMS*ENTRIES*OFFSET; AW = $clog2(DEPTH); BW = max(1,$clog2(BUFFER_COUNT)); CW = $clog2(BUFFER_COUNT+1).
REQ-003 SHALL have one clock and a synchronous, active-high reset; ports (name, direction, width, meaning):
- in_clk  input  1  clock, rising edge
- in_rst  input  1  synchronous active-high reset
- in_wr_valid  input  1  genome byte offered
- out_wr_ready  output  1  byte accepted when valid&&ready
- out_wr_en  output  1  RAM write strobe
- out_wr_buf  output  BW  buffer being filled
- out_wr_addr  output  AW  byte address in buffer
- in_rd_req  input  1  extender window request
- in_rd_addr  input  AW  window start byte
- in_rd_done  input  1  extender releases current buffer
- out_rd_en  output  1  RAM read strobe
- out_rd_buf  output  BW  buffer being read
- out_rd_addr  output  AW  window start to RAM
- out_rd_valid  output  1  window data valid on RAM output
- out_rd_err  output  1  illegal window request rejected
- out_rd_avail  output  1  a full buffer is owned by reader
- out_full_count  output  CW  number of full buffers

Function
REQ-004 Write accept SHALL occur when in_wr_valid && out_wr_ready; out_wr_en, out_wr_buf, out_wr_addr SHALL be combinational from that accept (same-cycle write).
REQ-005 out_wr_ready SHALL be 1 iff full_count < BUFFER_COUNT.
REQ-006 Write address SHALL increment per accept; on accept at DEPTH-1 it SHALL wrap to 0, wr_buf SHALL advance modulo BUFFER_COUNT, and full_count SHALL increment.
REQ-007 out_rd_avail SHALL be 1 iff full_count > 0; reader owns buffer rd_buf.
REQ-008 A request (in_rd_req && out_rd_avail) with in_rd_addr <= DEPTH-READ_ADDRESSES_COUNT SHALL assert out_rd_en, out_rd_buf=rd_buf, out_rd_addr=in_rd_addr in the same cycle, and out_rd_valid exactly one cycle later.
REQ-009 A request with in_rd_addr > DEPTH-READ_ADDRESSES_COUNT SHALL not assert out_rd_en and SHALL pulse out_rd_err one cycle later; no wrap across buffers.
REQ-010 A request with out_rd_avail=0 SHALL be ignored (no rd_en, no err).
REQ-011 Back-to-back requests SHALL be accepted every cycle (fully pipelined).
REQ-012 in_rd_done with out_rd_avail=1 SHALL advance rd_buf modulo BUFFER_COUNT and decrement full_count; with out_rd_avail=0 it SHALL be ignored.
REQ-013 in_rd_req and in_rd_done in the same cycle SHALL serve the request on the current rd_buf, then release.
REQ-014 Buffer-complete write and in_rd_done in the same cycle SHALL leave full_count unchanged while both indices advance.
REQ-015 full_count SHALL never exceed BUFFER_COUNT nor underflow.

Reset
REQ-016 With in_rst=1 at a clock edge: wr_buf, rd_buf, write address, full_count SHALL be 0; out_rd_valid, out_rd_err SHALL be 0; out_wr_ready SHALL be 1 after reset.
REQ-017 Reset mid-fill or mid-read SHALL discard partial buffer and pending out_rd_valid (no pulse after reset).

Structure
REQ-018 DEPTH/AW/BW helper functions and the FM_* constants SHALL live in proj_pkg.
REQ-019 Sub-module proj_fm_ring_ptr (modulo index counter with advance/wrap) SHALL be instantiated for wr_buf and rd_buf.

Verification
REQ-020 Reset, write DEPTH bytes -> full_count=1, out_rd_avail=1, out_wr_buf=1.
REQ-021 Fill all BUFFER_COUNT buffers -> out_wr_ready=0; further in_wr_valid produces no out_wr_en.
REQ-022 in_rd_req addr=0 -> out_rd_en same cycle, out_rd_valid next cycle; addr=DEPTH-READ_ADDRESSES_COUNT+1 -> out_rd_err pulse, no out_rd_en.
REQ-023 Last byte of a buffer written same cycle as in_rd_done -> full_count unchanged, both indices advance.
REQ-024 in_rd_req with full_count=0 -> no out_rd_en, no out_rd_err; in_rd_done with full_count=0 -> no change.
REQ-025 in_rst=1 with read in flight and half-filled buffer -> next cycle out_rd_valid=0, full_count=0, out_wr_addr=0.
